pc_sequencer: RTL
=================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter P, 6, program address width; equals the PC width.
REQ-002 Parameter IW, 16, instruction word width; opcode is instr[IW-1:IW-4] and imm is instr[P-1:0].
REQ-003 Parameter DEPTH, 4, number of call/return stack entries.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 instr  in  IW  registered program-ROM data; valid the cycle after the PC presents an address.
REQ-007 pc_in  in  P  current PC value.
REQ-008 flag_z  in  1  ALU zero flag.
REQ-009 flag_n  in  1  ALU negative flag.
REQ-010 stall  in  1  hold request from the datapath.
REQ-011 pc_incr  out  1  PC increment-by-1 request.
REQ-012 pc_rel  out  1  PC relative-add request: PC plus branch_addr.
REQ-013 pc_abs  out  1  PC load-absolute request: PC takes branch_addr.
REQ-014 branch_addr  out  P  branch offset or absolute target.
REQ-015 exec_en  out  1  enable for a datapath (ALU-class) instruction.
REQ-016 halted  out  1  HALT has executed.
REQ-017 trap  out  1  stack overflow or underflow has occurred.

Function
REQ-018 The FSM SHALL have states FETCH, EXEC, HALT and TRAP; FETCH always goes to EXEC on the next cycle.
REQ-019 In FETCH, every output pulse and branch_addr SHALL be 0.
REQ-020 In EXEC with stall=1, the block SHALL assert no outputs and remain in EXEC.
REQ-021 In EXEC with stall=0, the block SHALL assert exactly one of pc_incr/pc_rel/pc_abs, or none for HALT and trap cases, for that single cycle only, then go to FETCH; each instruction therefore takes 2 cycles.
REQ-022 pc_incr, pc_rel and pc_abs SHALL never be high together, in any state.
REQ-023 branch_addr SHALL be 0 whenever pc_rel and pc_abs are both low.
REQ-024 Outputs SHALL be combinational from the registered state and instr; the PC samples them on the closing edge of EXEC.
REQ-025 Opcodes 0x0-0x7 (ALU) SHALL give exec_en=1 and pc_incr=1.
REQ-026 Opcode 0xE (NOP) SHALL give pc_incr=1 with exec_en=0.
REQ-027 Opcodes 0x8 BEQ (taken if flag_z=1), 0x9 BNE (taken if flag_z=0) and 0xA BMI (taken if flag_n=1):
- taken: pc_rel=1, branch_addr=imm;
- not taken: pc_incr=1.
REQ-028 The relative offset is two's complement in P bits; wrap-around mod 2^P is the PC's responsibility, and this block SHALL NOT saturate it.
REQ-029 Opcode 0xB JMP SHALL give pc_abs=1 and branch_addr=imm.
REQ-030 Opcode 0xC CALL, stack not full:
- push (pc_in+1) mod 2^P;
- pc_abs=1, branch_addr=imm.
REQ-031 Opcode 0xD RET, stack not empty: pop the top entry, pc_abs=1, branch_addr=popped value.
REQ-032 The stack is LIFO with a count sp of 0..DEPTH; push and pop take effect on the same edge as the PC update.
REQ-033 CALL with sp=DEPTH, or RET with sp=0, SHALL issue no pulse, leave the stack unchanged and go to TRAP.
REQ-034 Opcode 0xF HALT SHALL issue no pulse and go to HALT.
REQ-035 HALT and TRAP SHALL be absorbing until reset.
REQ-036 In HALT and TRAP, all pulses SHALL be 0 and stall is ignored; halted=1 in HALT, trap=1 in TRAP.
REQ-037 flag_z and flag_n SHALL be sampled only in the EXEC cycle in which the branch issues, not while stalled.

Reset
REQ-038 reset=0 SHALL immediately force:
- state=FETCH, sp=0;
- pc_incr=pc_rel=pc_abs=0, branch_addr=0;
- exec_en=0, halted=0, trap=0.
REQ-039 Asserting reset mid-EXEC or mid-stall SHALL abort the instruction with no pulse issued; stack contents become don't-care.
REQ-040 After reset deasserts, the first EXEC SHALL occur on the second rising edge.

Verification
REQ-041 ALU opcode 0x3 -> FETCH cycle with no pulses, then EXEC cycle with exec_en=1 and pc_incr=1; PC 5 -> 6.
REQ-042 Branches with P=6, pc_in=2:
- BEQ imm=6'h3E, flag_z=1 -> pc_rel=1, branch_addr=6'h3E, PC becomes 0;
- same with flag_z=0 -> pc_incr=1, PC becomes 3.
REQ-043 Stack depth: CALL 0x10 at pc_in=4, then RET -> the RET cycle gives pc_abs=1 and branch_addr=5; five nested CALLs -> the fifth gives no pulse and trap=1 permanently.
REQ-044 Underflow and halt: RET after reset -> trap=1 with no pulse; HALT -> halted=1 and no pulses for 20 cycles, even with stall toggling.
REQ-045 Stall and reset: stall=1 for 3 EXEC cycles on JMP 0x21 -> no pulses, then a single pc_abs with branch_addr=0x21; reset asserted during the stall -> outputs go to 0 immediately and the JMP is never issued.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: two-cycle FETCH/EXEC control with branches,
// absolute jumps, a small call/return stack, HALT and TRAP end states.
module pc_sequencer #(
    parameter int unsigned P     = 6,
    parameter int unsigned IW    = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [IW-1:0] instr,
    input  logic [P-1:0]  pc_in,
    input  logic          flag_z,
    input  logic          flag_n,
    input  logic          stall,
    output logic          pc_incr,
    output logic          pc_rel,
    output logic          pc_abs,
    output logic [P-1:0]  branch_addr,
    output logic          exec_en,
    output logic          halted,
    output logic          trap
);

    localparam int unsigned OPW   = 4;
    localparam int unsigned SPW   = $clog2(DEPTH + 1);
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned SLOTS = 2 ** AW;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2,
        TRAP  = 2'd3
    } state_t;

    state_t         state;
    state_t         next_state;
    logic [SPW-1:0] sp;
    logic [P-1:0]   stack [SLOTS];
    logic [OPW-1:0] opcode;
    logic [P-1:0]   imm;
    logic [P-1:0]   top;
    logic           full;
    logic           empty;
    logic           push;
    logic           pop;
    logic           unused_bits;

    assign opcode      = instr[IW-1 -: OPW];
    assign imm         = instr[P-1:0];
    assign full        = (sp == SPW'(DEPTH));
    assign empty       = (sp == '0);
    assign top         = stack[AW'(sp - SPW'(1))];
    assign unused_bits = ^instr[IW-OPW-1:P];

    // Decode: next state, stack ops and PC requests from state and instruction
    always_comb begin
        next_state  = state;
        push        = 1'b0;
        pop         = 1'b0;
        pc_incr     = 1'b0;
        pc_rel      = 1'b0;
        pc_abs      = 1'b0;
        branch_addr = '0;
        exec_en     = 1'b0;
        halted      = 1'b0;
        trap        = 1'b0;
        case (state)
            FETCH: next_state = EXEC;
            EXEC: begin
                if (!stall) begin
                    next_state = FETCH;
                    case (opcode)
                        4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
                            exec_en = 1'b1;
                            pc_incr = 1'b1;
                        end
                        4'h8, 4'h9, 4'hA: begin
                            if ((opcode == 4'h8 && flag_z) ||
                                (opcode == 4'h9 && !flag_z) ||
                                (opcode == 4'hA && flag_n)) begin
                                pc_rel      = 1'b1;
                                branch_addr = imm;
                            end else begin
                                pc_incr = 1'b1;
                            end
                        end
                        4'hB: begin
                            pc_abs      = 1'b1;
                            branch_addr = imm;
                        end
                        4'hC: begin
                            if (full) begin
                                next_state = TRAP;
                            end else begin
                                push        = 1'b1;
                                pc_abs      = 1'b1;
                                branch_addr = imm;
                            end
                        end
                        4'hD: begin
                            if (empty) begin
                                next_state = TRAP;
                            end else begin
                                pop         = 1'b1;
                                pc_abs      = 1'b1;
                                branch_addr = top;
                            end
                        end
                        4'hE: pc_incr = 1'b1;
                        default: next_state = HALT;
                    endcase
                end
            end
            HALT: halted = 1'b1;
            default: trap = 1'b1;
        endcase
    end

    // State and stack-pointer registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FETCH;
            sp    <= '0;
        end else begin
            state <= next_state;
            if (push) begin
                sp <= sp + SPW'(1);
            end else if (pop) begin
                sp <= sp - SPW'(1);
            end
        end
    end

    // Return-address storage; contents are don't-care after reset
    always_ff @(posedge clk) begin
        if (push) begin
            stack[AW'(sp)] <= P'(pc_in + P'(1));
        end
    end

endmodule
